// File: rtl/scope_capture_buffer_pkg.sv
// Constants and state type shared by the capture buffer and the pixel discriminator.
package scope_capture_buffer_pkg;
  localparam int SAMPLE_W = 12;
  localparam int H_PIXELS = 800;
  localparam int X_W      = 10;

  localparam logic [X_W-1:0] H_PIX_X = X_W'(H_PIXELS);
  localparam logic [X_W-1:0] H_LAST  = X_W'(H_PIXELS - 1);

  typedef enum logic [1:0] {WAIT_TRIG, CAPTURE, DONE} state_e;

  // A decimation of 0 behaves like 1 (keep every sample).
  function automatic logic [7:0] eff_decim(input logic [7:0] d);
    return (d == 8'd0) ? 8'd1 : d;
  endfunction
endpackage

// File: rtl/scope_capture_buffer_if.sv
// Sample stream, trigger setup and pixel readout signals of the capture buffer.
interface scope_capture_buffer_if;
  import scope_capture_buffer_pkg::*;

  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample;
  logic [SAMPLE_W-1:0] trig_level;
  logic                trig_rising;
  logic [7:0]          decim;
  logic                frame_start;
  logic [X_W-1:0]      pixel_x;
  logic [SAMPLE_W-1:0] value;
  logic                armed;
  logic                frame_ready;

  modport master (
    output sample_valid, sample, trig_level, trig_rising, decim, frame_start, pixel_x,
    input  value, armed, frame_ready
  );

  modport slave (
    input  sample_valid, sample, trig_level, trig_rising, decim, frame_start, pixel_x,
    output value, armed, frame_ready
  );
endinterface

// File: rtl/scope_capture_buffer_sample_ram.sv
// Two-bank line store: synchronous write, registered read, maps onto block RAM.
module sample_ram
  import scope_capture_buffer_pkg::*;
(
  input  logic                clk,
  input  logic                we_i,
  input  logic                wr_bank_i,
  input  logic [X_W-1:0]      wr_idx_i,
  input  logic [SAMPLE_W-1:0] wr_dat_i,
  input  logic                rd_bank_i,
  input  logic [X_W-1:0]      rd_idx_i,
  output logic [SAMPLE_W-1:0] rd_dat_o
);
  logic [SAMPLE_W-1:0] mem [2][H_PIXELS];
  logic [SAMPLE_W-1:0] rd_dat_q;

  // Out-of-range columns read a harmless in-range word; the caller gates them to 0.
  always_ff @(posedge clk) begin
    if (we_i) mem[wr_bank_i][wr_idx_i] <= wr_dat_i;
    rd_dat_q <= mem[rd_bank_i][(rd_idx_i < H_PIX_X) ? rd_idx_i : '0];
  end

  assign rd_dat_o = rd_dat_q;
endmodule

// File: rtl/scope_capture_buffer.sv
// Captures one triggered, decimated record into a double-buffered line store and replays it per
// pixel_x with one cycle of latency; banks swap only on frame_start so the trace never tears.
module scope_capture_buffer
  import scope_capture_buffer_pkg::*;
#(
  parameter int AUTO_TIMEOUT = 65535
) (
  input logic                  clk,
  input logic                  reset,
  scope_capture_buffer_if.slave bus
);
  localparam bit          AUTO_EN = (AUTO_TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = 16'(AUTO_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                bank_q, bank_d;  // write bank; the read bank is always the other one
  logic                has_frame_q, has_frame_d;
  logic [SAMPLE_W-1:0] prev_q, prev_d;
  logic                prev_vld_q, prev_vld_d;
  logic [15:0]         to_cnt_q, to_cnt_d;
  logic [7:0]          dec_cnt_q, dec_cnt_d;
  logic [7:0]          decim_q, decim_d;
  logic [X_W-1:0]      wr_addr_q, wr_addr_d;
  logic [X_W-1:0]      wr_idx;
  logic                we;
  logic                gate_q;
  logic                edge_hit;
  logic                auto_hit;
  logic [7:0]          decim_eff;
  logic [SAMPLE_W-1:0] rd_dat;

  assign decim_eff = eff_decim(bus.decim);
  assign auto_hit  = AUTO_EN && (to_cnt_q == TO_LAST);

  always_comb begin
    edge_hit = 1'b0;
    if (prev_vld_q) begin
      if (bus.trig_rising) edge_hit = (prev_q < bus.trig_level) && (bus.sample >= bus.trig_level);
      else                 edge_hit = (prev_q > bus.trig_level) && (bus.sample <= bus.trig_level);
    end
  end

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    has_frame_d = has_frame_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    to_cnt_d    = to_cnt_q;
    dec_cnt_d   = dec_cnt_q;
    decim_d     = decim_q;
    wr_addr_d   = wr_addr_q;
    wr_idx      = wr_addr_q;
    we          = 1'b0;
    case (state_q)
      WAIT_TRIG: begin
        if (bus.sample_valid) begin
          prev_d     = bus.sample;
          prev_vld_d = 1'b1;
          to_cnt_d   = to_cnt_q + 16'd1;
          if (edge_hit || auto_hit) begin
            we        = 1'b1;
            wr_idx    = '0;
            wr_addr_d = X_W'(1);
            decim_d   = decim_eff;
            dec_cnt_d = (decim_eff == 8'd1) ? 8'd0 : 8'd1;
            state_d   = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (bus.sample_valid) begin
          if (dec_cnt_q == 8'd0) begin
            we        = 1'b1;
            wr_addr_d = wr_addr_q + X_W'(1);
            if (wr_addr_q == H_LAST) state_d = DONE;
          end
          dec_cnt_d = (dec_cnt_q == decim_q - 8'd1) ? 8'd0 : dec_cnt_q + 8'd1;
        end
      end
      DONE: begin
        if (bus.frame_start) begin
          bank_d      = ~bank_q;
          has_frame_d = 1'b1;
          to_cnt_d    = '0;
          prev_vld_d  = 1'b0;
          state_d     = WAIT_TRIG;
        end
      end
      default: state_d = WAIT_TRIG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_TRIG;
      bank_q      <= 1'b0;
      has_frame_q <= 1'b0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      to_cnt_q    <= '0;
      dec_cnt_q   <= '0;
      decim_q     <= 8'd1;
      wr_addr_q   <= '0;
      gate_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      has_frame_q <= has_frame_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      to_cnt_q    <= to_cnt_d;
      dec_cnt_q   <= dec_cnt_d;
      decim_q     <= decim_d;
      wr_addr_q   <= wr_addr_d;
      gate_q      <= has_frame_q && (bus.pixel_x < H_PIX_X);
    end
  end

  sample_ram u_ram (
    .clk       (clk),
    .we_i      (we),
    .wr_bank_i (bank_q),
    .wr_idx_i  (wr_idx),
    .wr_dat_i  (bus.sample),
    .rd_bank_i (~bank_q),
    .rd_idx_i  (bus.pixel_x),
    .rd_dat_o  (rd_dat)
  );

  assign bus.value       = gate_q ? rd_dat : '0;
  assign bus.armed       = (state_q == WAIT_TRIG);
  assign bus.frame_ready = (state_q == DONE);
endmodule

// File: tb/tb_scope_capture_buffer.sv
// Directed scenarios for the capture buffer; a scoreboard queue is checked by a separate monitor.
module tb_scope_capture_buffer;
  logic clk = 1'b0;
  logic reset = 1'b1;

  scope_capture_buffer_if bus();

  scope_capture_buffer #(.AUTO_TIMEOUT(1000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int exp; } st_t;   // kind 0 = armed, 1 = frame_ready
  typedef struct { int x; int exp; } rd_t;

  st_t st_q[$];
  rd_t rd_q[$];
  int  n_vec = 0;
  int  n_bad = 0;
  logic rd_req = 1'b0;
  logic rd_req_d = 1'b0;

  always @(posedge clk) rd_req_d <= rd_req;

  // Status expectations refer to the current cycle; reads refer to the value one edge later.
  always @(negedge clk) begin
    st_t s;
    rd_t r;
    int  act;
    while (st_q.size() > 0) begin
      s = st_q.pop_front();
      act = (s.kind == 0) ? int'(bus.armed) : int'(bus.frame_ready);
      n_vec++;
      if (act != s.exp) begin
        n_bad++;
        $display("FAIL %s: got %0d want %0d at %0t", (s.kind == 0) ? "armed" : "frame_ready",
                 act, s.exp, $time);
      end
    end
    if (rd_req_d) begin
      n_vec++;
      if (rd_q.size() == 0) begin
        n_bad++;
        $display("FAIL value: output with no expected entry at %0t", $time);
      end else begin
        r = rd_q.pop_front();
        if (int'(bus.value) != r.exp) begin
          n_bad++;
          $display("FAIL value@x=%0d: got %0d want %0d at %0t", r.x, bus.value, r.exp, $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s, input bit fs = 1'b0);
    bus.sample_valid = 1'b1;
    bus.sample       = 12'(s);
    bus.frame_start  = fs;
    tick();
    bus.sample_valid = 1'b0;
    bus.frame_start  = 1'b0;
  endtask

  task automatic pulse_fs();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic exp_st(input int kind, input int v);
    st_t s;
    s.kind = kind;
    s.exp  = v;
    st_q.push_back(s);
  endtask

  task automatic rd(input int x, input int v);
    rd_t r;
    r.x = x;
    r.exp = v;
    rd_q.push_back(r);
    bus.pixel_x = 10'(x);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic ramp_up(input int a, input int b);
    for (int i = a; i <= b; i++) send(8 * i);
  endtask

  task automatic ramp_dn(input int a, input int b);
    for (int i = a; i <= b; i++) send(4000 - 8 * i);
  endtask

  task automatic send_const(input int n, input int v);
    for (int i = 0; i < n; i++) send(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample       = '0;
    bus.trig_level   = 12'd2048;
    bus.trig_rising  = 1'b1;
    bus.decim        = 8'd1;
    bus.frame_start  = 1'b0;
    bus.pixel_x      = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state and readout before any swap
    exp_st(0, 1); exp_st(1, 0);
    rd(0, 0); rd(5, 0);

    // Rising ramp, decim 1: trigger on 2048 (ramp index 256)
    ramp_up(0, 255);    exp_st(0, 1);
    ramp_up(256, 256);  exp_st(0, 0);
    ramp_up(257, 1054); exp_st(1, 0);
    ramp_up(1055, 1055); exp_st(1, 1);
    rd(0, 0);
    pulse_fs();         exp_st(0, 1); exp_st(1, 0);
    rd(0, 2048); rd(5, 2088); rd(255, 4088); rd(256, 0); rd(799, 248);
    rd(800, 0); rd(1023, 0);

    // Decim 4, frame_start during capture, decim change ignored, frame_start on last write
    bus.decim = 8'd4;
    ramp_up(0, 656);
    pulse_fs();         exp_st(0, 0); exp_st(1, 0);
    rd(5, 2088);
    bus.decim = 8'd2;
    ramp_up(657, 3451); exp_st(1, 0);
    send(8 * 3452, 1'b1); exp_st(1, 1);
    tick();             exp_st(1, 1);
    rd(5, 2088);
    pulse_fs();         exp_st(0, 1);
    rd(0, 2048); rd(1, 2080); rd(64, 0); rd(100, 1152); rd(799, 3040);

    // Auto trigger after 1000 untriggered valid samples
    bus.decim = 8'd1;
    send_const(999, 100); exp_st(0, 1);
    send_const(1, 100);   exp_st(0, 0);
    send_const(798, 100); exp_st(1, 0);
    send_const(1, 100);   exp_st(1, 1);
    pulse_fs();
    rd(0, 100); rd(400, 100); rd(799, 100);

    // Falling trigger, reset with wr_addr at 400
    bus.trig_rising = 1'b0;
    bus.trig_level  = 12'd2000;
    ramp_dn(0, 649);    exp_st(0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_st(0, 1); exp_st(1, 0);
    rd(0, 0); rd(799, 0);

    // First sample after reset only loads prev, even if it looks like an edge
    bus.trig_rising = 1'b1;
    bus.trig_level  = 12'd2048;
    send(3000);         exp_st(0, 1);

    // Fresh falling-edge capture completes and displays correctly
    bus.trig_rising = 1'b0;
    bus.trig_level  = 12'd2000;
    ramp_dn(0, 249);    exp_st(0, 1);
    ramp_dn(250, 250);  exp_st(0, 0);
    ramp_dn(251, 1048); exp_st(1, 0);
    ramp_dn(1049, 1049); exp_st(1, 1);
    pulse_fs();
    rd(0, 2000); rd(1, 1992); rd(250, 0); rd(251, 4088); rd(799, 3800);

    repeat (3) tick();
    n_vec++;
    if (st_q.size() != 0 || rd_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d pending want 0/0", st_q.size(), rd_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
